// File: rtl/ysyx_22040088_mem_arb.sv
// Shared memory-port arbiter for instruction fetch (IF) and load/store (LS).
// One transaction in flight; LS has priority, bounded by a streak limit so IF cannot starve.
module ysyx_22040088_mem_arb #(
  parameter int unsigned LS_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_inst,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_addr,
  input  logic        ls_wen,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_resp_valid,
  output logic [63:0] ls_resp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata
);

  localparam int unsigned StreakW = $clog2(LS_STREAK_MAX + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q;
  logic                 owner_ls_q;
  logic [63:0]          addr_q;
  logic                 wen_q;
  logic [63:0]          wdata_q;
  logic [7:0]           wmask_q;
  logic [2:0]           off_q;
  logic [StreakW-1:0]   streak_q;
  logic                 mem_req_valid_q;
  logic                 if_resp_valid_q;
  logic                 ls_resp_valid_q;
  logic [31:0]          if_inst_q;
  logic [63:0]          ls_rdata_q;

  logic streak_full, if_win, ls_win, idle;

  always_comb begin
    streak_full = (streak_q == StreakW'(LS_STREAK_MAX));
    if_win      = if_req_valid & (~ls_req_valid | streak_full);
    ls_win      = ls_req_valid & ~if_win;
    idle        = (state_q == StIdle);
  end

  // Readies are gated by reset so nothing is accepted while the block is held in reset.
  assign if_req_ready  = rst & idle & if_win;
  assign ls_req_ready  = rst & idle & ls_win;

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_inst  = if_inst_q;
  assign ls_resp_valid = ls_resp_valid_q;
  assign ls_resp_rdata = ls_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      owner_ls_q      <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      off_q           <= '0;
      streak_q        <= '0;
      mem_req_valid_q <= 1'b0;
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      if_inst_q       <= '0;
      ls_rdata_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ls_win) begin
            owner_ls_q      <= 1'b1;
            addr_q          <= ls_addr;
            wen_q           <= ls_wen;
            wdata_q         <= ls_wdata;
            wmask_q         <= ls_wmask;
            mem_req_valid_q <= 1'b1;
            state_q         <= StIssue;
            // Only count LS wins that actually held IF off.
            if (!if_req_valid)     streak_q <= '0;
            else if (!streak_full) streak_q <= streak_q + StreakW'(1);
          end else if (if_win) begin
            owner_ls_q      <= 1'b0;
            addr_q          <= {if_addr[63:3], 3'b000};
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            off_q           <= if_addr[2:0];
            mem_req_valid_q <= 1'b1;
            streak_q        <= '0;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= StWait;
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            if (owner_ls_q) begin
              ls_rdata_q      <= mem_resp_rdata;
              ls_resp_valid_q <= 1'b1;
            end else begin
              // Only word-aligned fetches yield an instruction; anything else reads as zero.
              unique case (off_q)
                3'b000:  if_inst_q <= mem_resp_rdata[31:0];
                3'b100:  if_inst_q <= mem_resp_rdata[63:32];
                default: if_inst_q <= 32'h0;
              endcase
              if_resp_valid_q <= 1'b1;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          if_resp_valid_q <= 1'b0;
          ls_resp_valid_q <= 1'b0;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_mem_arb.sv
// Scoreboard bench for the IF/LS memory arbiter: the bench plays the memory side and
// queues the expected response of every grant for a negedge monitor to compare.
module tb_ysyx_22040088_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr;
  logic [31:0] if_resp_inst;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_resp_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_rdata;
  logic [7:0]  mem_wmask;

  typedef struct packed {
    logic        ls;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_22040088_mem_arb #(.LS_STREAK_MAX(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_inst   (if_resp_inst),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_addr        (ls_addr),
    .ls_wen         (ls_wen),
    .ls_wdata       (ls_wdata),
    .ls_wmask       (ls_wmask),
    .ls_resp_valid  (ls_resp_valid),
    .ls_resp_rdata  (ls_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    #2;
    if (if_resp_valid || ls_resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", {62'h0, if_resp_valid, ls_resp_valid}, 64'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_owner", {62'h0, if_resp_valid, ls_resp_valid}, {62'h0, ~mon_e.ls, mon_e.ls});
        if (mon_e.ls) check("ls_rdata", ls_resp_rdata, mon_e.data);
        else          check("if_inst", {32'h0, if_resp_inst}, mon_e.data);
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if_req_valid   = 1'b0;
      ls_req_valid   = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
    end
  endtask

  // One full transaction: grant, issue (rdy_dly stall cycles), wait (rsp_dly cycles), resp.
  task automatic txn(input logic ifv, input logic lsv, input logic [63:0] ia,
                     input logic [63:0] la, input logic lwen, input logic [63:0] lwd,
                     input logic [7:0] lwm, input bit exp_ls, input logic [63:0] rd,
                     input int rdy_dly, input int rsp_dly, input bit stray);
    logic [63:0] e_addr, e_wd, sel;
    logic        e_wen;
    logic [7:0]  e_wm;
    @(negedge clk);
    if_req_valid = ifv; if_addr = ia;
    ls_req_valid = lsv; ls_addr = la; ls_wen = lwen; ls_wdata = lwd; ls_wmask = lwm;
    mem_req_ready  = 1'b0;
    mem_resp_valid = stray;
    mem_resp_rdata = ~rd;
    #1;
    check("if_ready", {63'h0, if_req_ready}, {63'h0, ~exp_ls});
    check("ls_ready", {63'h0, ls_req_ready}, {63'h0, exp_ls});
    if (exp_ls) begin
      e_addr = la; e_wen = lwen; e_wd = lwd; e_wm = lwm;
      sb_q.push_back('{ls: 1'b1, data: rd});
    end else begin
      e_addr = {ia[63:3], 3'b000}; e_wen = 1'b0; e_wd = 64'h0; e_wm = 8'h0;
      case (ia[2:0])
        3'b000:  sel = {32'h0, rd[31:0]};
        3'b100:  sel = {32'h0, rd[63:32]};
        default: sel = 64'h0;
      endcase
      sb_q.push_back('{ls: 1'b0, data: sel});
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      @(negedge clk);
      mem_req_ready  = (k == rdy_dly);
      mem_resp_valid = stray && (k == 0);
      #1;
      check("issue_valid", {63'h0, mem_req_valid}, 64'h1);
      check("issue_addr", mem_addr, e_addr);
      check("issue_fields", {mem_wdata[54:0], mem_wen, mem_wmask}, {e_wd[54:0], e_wen, e_wm});
      check("issue_readies", {62'h0, if_req_ready, ls_req_ready}, 64'h0);
    end
    for (int k = 0; k <= rsp_dly; k++) begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = (k == rsp_dly);
      mem_resp_rdata = (k == rsp_dly) ? rd : ~rd;
      #1;
      check("wait_req_low", {63'h0, mem_req_valid}, 64'h0);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("resp_pulse", {62'h0, if_resp_valid, ls_resp_valid}, {62'h0, ~exp_ls, exp_ls});
    check("resp_readies", {62'h0, if_req_ready, ls_req_ready}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    ls_req_valid = 1'b1; ls_addr = 64'h0; ls_wen = 1'b0; ls_wdata = 64'h0; ls_wmask = 8'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;
    #12;
    check("rst_readies", {62'h0, if_req_ready, ls_req_ready}, 64'h0);
    check("rst_mem", {mem_addr[62:0], mem_req_valid}, 64'h0);
    check("rst_resp", {if_resp_inst[29:0], if_resp_valid, ls_resp_valid}, 32'h0);
    idle_cycles(1);
    rst = 1'b1;
    idle_cycles(1);

    // IF only, upper word; data must hold after the pulse.
    txn(1, 0, 64'h8000_0004, 0, 0, 0, 0, 0, 64'h0010_0073_0000_0413, 0, 0, 0);
    idle_cycles(1);
    #1;
    check("inst_hold", {32'h0, if_resp_inst}, 64'h0010_0073);
    check("valid_low", {62'h0, if_resp_valid, ls_resp_valid}, 64'h0);
    // Lower word, then misaligned.
    txn(1, 0, 64'h8000_1000, 0, 0, 0, 0, 0, 64'h1111_2222_3333_4444, 0, 1, 0);
    txn(1, 0, 64'h8000_0002, 0, 0, 0, 0, 0, 64'h0010_0073_0000_0413, 0, 0, 0);

    // Back-pressured LS store with IF also pending (streak 0 -> LS wins).
    txn(1, 1, 64'h8000_0000, 64'h8000_2010, 1, 64'hDEAD_BEEF, 8'h0F, 1, 64'h0, 5, 0, 0);
    // LS grant with IF idle resets the streak.
    txn(0, 1, 0, 64'h8000_3008, 0, 0, 0, 1, 64'hCAFE_F00D_1234_5678, 0, 2, 0);

    // Contention: LS x4, IF, LS x4, IF.
    for (int i = 0; i < 10; i++) begin
      txn(1, 1, 64'h8000_4000 + 64'(i * 4), 64'h8000_5000 + 64'(i * 8), 0, 0, 0,
          (i % 5) != 4, 64'hA5A5_0000_0000_0000 + 64'(i), 0, 0, 0);
    end
    idle_cycles(2);

    // Stray responses in IDLE and ISSUE are ignored.
    txn(1, 0, 64'h8000_6000, 0, 0, 0, 0, 0, 64'h0BAD_0BAD_600D_600D, 2, 1, 1);
    idle_cycles(2);

    // Reset while waiting for the memory response.
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h8000_7004;
    @(negedge clk);
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; if_req_valid = 1'b1; ls_req_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_wait_readies", {62'h0, if_req_ready, ls_req_ready}, 64'h0);
    check("rst_wait_mem", {mem_addr[62:0], mem_req_valid}, 64'h0);
    check("rst_wait_mfields", {mem_wdata[62:0], mem_wen}, 64'h0);
    @(negedge clk);
    rst = 1'b1; if_req_valid = 1'b0; ls_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("late_resp_ignored", {62'h0, if_resp_valid, ls_resp_valid}, 64'h0);
    check("late_req_low", {63'h0, mem_req_valid}, 64'h0);
    txn(1, 0, 64'h8000_8000, 0, 0, 0, 0, 0, 64'h7777_8888_9999_AAAA, 1, 0, 0);
    idle_cycles(3);

    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_mem_arb.md
Name: ysyx_22040088_mem_arb

Overview:
- Arbitrates one shared memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- One transaction is outstanding at a time. Requests use valid/ready handshakes; responses are single-cycle pulses.
- LS has fixed priority over IF, with a streak limit so IF is never starved.
- For IF responses, the block selects the 32-bit instruction word from the 64-bit memory beat.

Parameters:
- LS_STREAK_MAX, 4: maximum consecutive LS grants while IF is pending before IF is forced to win. Legal range ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- if_req_valid  in  1  IF fetch request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  64  fetch PC.
- if_resp_valid  out  1  one-cycle pulse: if_resp_inst is valid.
- if_resp_inst  out  32  fetched instruction.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_addr  in  64  LS address.
- ls_wen  in  1  1 = store, 0 = load.
- ls_wdata  in  64  store data.
- ls_wmask  in  8  store byte mask.
- ls_resp_valid  out  1  one-cycle pulse: ls_resp_rdata is valid (pulses for stores too).
- ls_resp_rdata  out  64  load data.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  64  memory address.
- mem_wen  out  1  write enable.
- mem_wdata  out  64  write data.
- mem_wmask  out  8  write mask.
- mem_resp_valid  in  1  memory response.
- mem_resp_rdata  in  64  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; the streak counter, owner and all latched registers clear.
  - All outputs are 0, including both ready signals (gated by rst).
  - Any in-flight transaction is dropped. A late mem_resp_valid after reset is ignored because the state is IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Readies are combinational: exactly one ready is high, and only for the winner, when some valid is high.
  - On a grant: latch owner, address, wen, wdata and wmask; next state is ISSUE.
  - With no valid, stay in IDLE.
- Arbitration:
  - LS wins when both are valid, unless streak == LS_STREAK_MAX, in which case IF wins.
  - Streak counter increments on an LS grant while if_req_valid=1; saturates at LS_STREAK_MAX.
  - Streak counter clears on any IF grant, or on an LS grant with if_req_valid=0.
- IF request latching:
  - mem_addr = {if_addr[63:3], 3'b000}; mem_wen=0; mem_wmask=0; mem_wdata=0.
  - Save if_addr[2:0] for word selection.
- LS request latching: all fields pass through unchanged.
- ISSUE: mem_req_valid=1 with latched fields held stable. On mem_req_ready=1, go to WAIT. mem_resp_valid in ISSUE is ignored.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid=1: capture mem_resp_rdata and go to RESP.
  - No timeout; the block waits indefinitely.
- RESP (exactly one cycle), then IDLE:
  - IF owner: if_resp_valid=1. if_resp_inst is rdata[31:0] when saved addr[2:0]=000, rdata[63:32] when 100, otherwise 32'h0.
  - LS owner: ls_resp_valid=1, ls_resp_rdata=rdata.
- Response outputs:
  - Data outputs hold their last value outside RESP; valid signals are 0.
  - Requesters cannot back-pressure responses.
- Latency: grant at cycle T; mem_req_valid at T+1. If mem_req_ready is high at T+1 and mem_resp_valid at T+2, the resp pulse is at T+3. Minimum of 4 cycles between grants.
- Requester valid may drop without a grant; no request is generated. Inputs are sampled only on the grant cycle.
- mem_resp_valid in IDLE or RESP is ignored.

Test Plan:
1. IF only: if_addr=0x80000004; mem accepts immediately and returns rdata=0x00100073_00000413 one cycle later → if_req_ready high at T, mem_addr=0x80000000, if_resp_valid at T+3, if_resp_inst=0x00100073.
2. Misaligned fetch: if_addr=0x80000002 → if_resp_inst=0x00000000; transaction still completes with a single pulse.
3. Contention: IF and LS held valid continuously with LS_STREAK_MAX=4 → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF,…; streak clears after each IF grant.
4. Back-pressure: mem_req_ready low for 5 cycles → mem_req_valid held with a stable address and LS store fields (wen=1, wmask=0x0F, wdata=0xDEADBEEF); both readies stay 0 until after RESP.
5. Reset mid-WAIT: rst=0 for one cycle, then mem_resp_valid arrives → no resp pulse, all outputs 0, FSM in IDLE; the next IF request completes normally.
6. Stray response: mem_resp_valid pulsed in IDLE and in ISSUE → ignored, no resp pulse; the transaction completes with the later WAIT-state response.
